// File: rtl/tmr_scrub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_scrub_ctrl
//  Purpose  : Access initiator and patrol scrubber for a triplicated (TMR)
//             memory. Arbitrates the host port against a background patrol
//             reader that walks the full address space at a fixed interval,
//             and keeps the cycle after every read free of writes so the
//             memory can complete its scrub write-back.
//  Options  : TMR_SCRUB_STATS_EN - build the saturating completed-sweep
//             counter (sweep_count); otherwise sweep_count is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module tmr_scrub_ctrl #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int SCRUB_INTERVAL = 256,
    parameter int MAX_DEFER      = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scrub_en,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic              m_we,
    output logic              m_re,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [ADDR_W-1:0] patrol_addr,
    output logic              sweep_done,
    output logic [15:0]       sweep_count
);

    localparam int c_INT_W = $clog2(SCRUB_INTERVAL);
    localparam int c_DEF_W = $clog2(MAX_DEFER + 1);
    localparam logic [c_INT_W-1:0] c_RELOAD    = c_INT_W'(SCRUB_INTERVAL - 1);
    localparam logic [c_DEF_W-1:0] c_DEFER_MAX = c_DEF_W'(MAX_DEFER);
    localparam logic [ADDR_W-1:0]  c_LAST_ADDR = '1;

    typedef enum logic [0:0] {
        CNT  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_INT_W-1:0]  r_int_cnt;
    logic [c_DEF_W-1:0]  r_defer_cnt;
    logic [ADDR_W-1:0]   r_patrol_addr;
    logic                r_guard;
    logic [1:0]          r_tag;

    logic w_pend_live;
    logic w_forced;
    logic w_host_gnt;
    logic w_patrol_issue;

    // Arbitration: a starved patrol wins, then the host, then a pending patrol.
    // A host write is held off while the previous cycle issued a read.
    always_comb begin
        w_pend_live    = (r_state == PEND) && scrub_en;
        w_forced       = w_pend_live && (r_defer_cnt == c_DEFER_MAX);
        w_host_gnt     = !rst && !w_forced && h_req && !(h_we && r_guard);
        w_patrol_issue = !rst && w_pend_live && !w_host_gnt;
    end

    // Memory-side and host-side outputs, all forced low while in reset.
    always_comb begin
        h_gnt      = w_host_gnt;
        m_we       = w_host_gnt && h_we;
        m_re       = (w_host_gnt && !h_we) || w_patrol_issue;
        m_addr     = '0;
        if (w_host_gnt) begin
            m_addr = h_addr;
        end else if (w_patrol_issue) begin
            m_addr = r_patrol_addr;
        end
        m_wdata     = w_host_gnt ? h_wdata : '0;
        h_rvalid    = !rst && r_tag[1];
        h_rdata     = h_rvalid ? m_rdata : '0;
        sweep_done  = w_patrol_issue && (r_patrol_addr == c_LAST_ADDR);
        patrol_addr = r_patrol_addr;
    end

    // Patrol FSM, interval/defer counters, write guard and read-tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= CNT;
            r_int_cnt     <= c_RELOAD;
            r_defer_cnt   <= '0;
            r_patrol_addr <= '0;
            r_guard       <= 1'b0;
            r_tag         <= 2'b00;
        end else begin
            r_guard <= m_re;
            // Only host reads are tagged; patrol read data is dropped.
            r_tag   <= {r_tag[0], w_host_gnt && !h_we};
            case (r_state)
                CNT: begin
                    r_defer_cnt <= '0;
                    if (scrub_en) begin
                        if (r_int_cnt == '0) begin
                            r_state <= PEND;
                        end else begin
                            r_int_cnt <= r_int_cnt - 1'b1;
                        end
                    end
                end
                PEND: begin
                    if (!scrub_en) begin
                        r_state     <= CNT;
                        r_int_cnt   <= c_RELOAD;
                        r_defer_cnt <= '0;
                    end else if (w_patrol_issue) begin
                        r_state       <= CNT;
                        r_int_cnt     <= c_RELOAD;
                        r_defer_cnt   <= '0;
                        r_patrol_addr <= r_patrol_addr + 1'b1;
                    end else if (r_defer_cnt != c_DEFER_MAX) begin
                        r_defer_cnt <= r_defer_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= CNT;
                end
            endcase
        end
    end

`ifdef TMR_SCRUB_STATS_EN
    logic [15:0] r_sweep_count;

    // Completed-sweep counter, saturating so it never wraps back to a small value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sweep_count <= 16'd0;
        end else if (sweep_done && (r_sweep_count != 16'hFFFF)) begin
            r_sweep_count <= r_sweep_count + 16'd1;
        end
    end

    assign sweep_count = r_sweep_count;
`else
    assign sweep_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tmr_scrub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmr_scrub_ctrl
//  Purpose  : Self-checking bench for tmr_scrub_ctrl with a small triplicated
//             memory model (majority vote, write-back one cycle after a read,
//             2-cycle read latency).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tmr_scrub_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       scrub_en;
    logic       h_req;
    logic       h_we;
    logic [7:0] h_addr;
    logic [7:0] h_wdata;
    logic       h_gnt;
    logic       h_rvalid;
    logic [7:0] h_rdata;
    logic       m_we;
    logic       m_re;
    logic [7:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_rdata;
    logic [7:0] patrol_addr;
    logic       sweep_done;
    logic [15:0] sweep_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tmr_scrub_ctrl #(
        .ADDR_W(8), .DATA_W(8), .SCRUB_INTERVAL(4), .MAX_DEFER(3)
    ) dut (
        .clk(clk), .rst(rst), .scrub_en(scrub_en),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_we(m_we), .m_re(m_re), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .patrol_addr(patrol_addr),
        .sweep_done(sweep_done), .sweep_count(sweep_count)
    );

    // ---------------- triplicated memory model ----------------
    logic [7:0] rep0 [256];
    logic [7:0] rep1 [256];
    logic [7:0] rep2 [256];
    logic       mem_init;
    logic       corrupt;
    logic       p1_valid = 1'b0;
    logic [7:0] p1_addr  = 8'h00;
    logic [7:0] rd_q     = 8'h00;
    int         collisions = 0;

    assign m_rdata = rd_q;

    always @(posedge clk) begin
        logic [7:0] v;
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                rep0[i] <= 8'(i) ^ 8'h5A;
                rep1[i] <= 8'(i) ^ 8'h5A;
                rep2[i] <= 8'(i) ^ 8'h5A;
            end
        end else begin
            if (corrupt) rep1[8'h20] <= rep0[8'h20] ^ 8'hFF;
            if (m_we) begin
                rep0[m_addr] <= m_wdata;
                rep1[m_addr] <= m_wdata;
                rep2[m_addr] <= m_wdata;
                if (p1_valid) collisions <= collisions + 1;
            end
            if (p1_valid) begin
                v = (rep0[p1_addr] & rep1[p1_addr]) | (rep0[p1_addr] & rep2[p1_addr]) |
                    (rep1[p1_addr] & rep2[p1_addr]);
                rep0[p1_addr] <= v;
                rep1[p1_addr] <= v;
                rep2[p1_addr] <= v;
                rd_q <= v;
            end
            p1_valid <= m_re;
            p1_addr  <= m_addr;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        h_req = 1'b0; h_we = 1'b0; h_addr = 8'h00; h_wdata = 8'h00;
    endtask

    task automatic do_reset(input logic en);
        rst = 1'b1;
        idle_inputs();
        scrub_en = en;
        next();
        next();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       req;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       gnt;
        logic       mwe;
        logic       mre;
        logic [7:0] maddr;
        logic [7:0] mwdata;
        logic       rvalid;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int  k;
        int  c;
        bit  found;

        // host traffic with patrol disabled: guard, latency, back-to-back reads
        vecs[0] = '{1'b1, 1'b1, 8'h10, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h10, 8'hA5, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 8'h11, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 8'h11, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h11, 8'h3C, 1'b1, 8'hA5};
        vecs[4] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 8'h00, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h3C};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hA5};
        vecs[8] = '{1'b1, 1'b1, 8'h12, 8'h77, 1'b1, 1'b1, 1'b0, 8'h12, 8'h77, 1'b0, 8'h00};

        rst = 1'b1; scrub_en = 1'b0; corrupt = 1'b0; mem_init = 1'b1;
        idle_inputs();
        next();
        mem_init = 1'b0;

        // ---- outputs gated while in reset, even with a host request present
        h_req = 1'b1; h_addr = 8'h33; scrub_en = 1'b1;
        @(negedge clk);
        check("reset_outputs", {h_gnt, m_re, m_we, m_addr, m_wdata, h_rvalid, sweep_done},
              '0);
        next();
        @(negedge clk);
        check("reset_state", {patrol_addr, sweep_count}, {8'h00, 16'h0000});
        next();

        // ---- table-driven host traffic
        rst = 1'b0; scrub_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            h_req = vecs[i].req; h_we = vecs[i].we;
            h_addr = vecs[i].addr; h_wdata = vecs[i].wdata;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {h_gnt, m_we, m_re, m_addr, m_wdata, h_rvalid, h_rdata},
                  {vecs[i].gnt, vecs[i].mwe, vecs[i].mre, vecs[i].maddr,
                   vecs[i].mwdata, vecs[i].rvalid, vecs[i].rdata});
            next();
        end
        idle_inputs();

        // ---- continuous host reads vs pending patrol (MAX_DEFER=3)
        do_reset(1'b1);
        h_req = 1'b1; h_we = 1'b0; h_addr = 8'h05;
        for (c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("defer_c%0d", c), {h_gnt, m_re, m_addr, h_rvalid},
                  {(c != 7), 1'b1, (c == 7) ? 8'h00 : 8'h05, (c >= 2) && (c != 9)});
            next();
        end
        idle_inputs();

        // ---- reset mid-sweep with a host read in flight
        do_reset(1'b1);
        found = 1'b0;
        for (c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            if (patrol_addr == 8'h37) found = 1'b1;
            next();
        end
        check("reach_patrol_37", found, 1'b1);
        h_req = 1'b1; h_we = 1'b0; h_addr = 8'h44;
        @(negedge clk);
        check("midsweep_host_gnt", {h_gnt, m_re, m_addr}, {1'b1, 1'b1, 8'h44});
        next();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        check("midsweep_rst_gated", {h_rvalid, m_re}, 2'b00);
        next();
        rst = 1'b0;
        for (c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) check("midsweep_addr0", patrol_addr, 8'h00);
            check($sformatf("midsweep_c%0d", c), {h_rvalid, m_re, m_addr},
                  {1'b0, (c == 4), 8'h00});
            next();
        end

        // ---- full patrol sweep (SCRUB_INTERVAL=4) with replica 1 corrupted at 0x20
        rst = 1'b1; scrub_en = 1'b0; corrupt = 1'b1;
        next();
        corrupt = 1'b0;
        check("corrupt_applied", rep1[8'h20], 8'h85);
        do_reset(1'b1);
        k = 0;
        for (c = 0; c < 1400 && k < 256; c++) begin
            @(negedge clk);
            if (m_re) begin
                check($sformatf("patrol_k%0d", k), {32'(c), m_addr, sweep_done, h_gnt},
                      {32'(4 + 5 * k), 8'(k), (k == 255), 1'b0});
                k++;
            end else if (sweep_done) begin
                check("stray_sweep_done", sweep_done, 1'b0);
            end
            next();
        end
        check("sweep_complete", 32'(k), 32'd256);
        scrub_en = 1'b0;
        @(negedge clk);
`ifdef TMR_SCRUB_STATS_EN
        check("sweep_count", sweep_count, 16'd1);
`else
        check("sweep_count", sweep_count, 16'd0);
`endif
        check("patrol_wrapped", patrol_addr, 8'h00);
        check("replica_repaired", {rep0[8'h20], rep1[8'h20], rep2[8'h20]},
              {8'h7A, 8'h7A, 8'h7A});
        next();

        // host read of the repaired word
        h_req = 1'b1; h_we = 1'b0; h_addr = 8'h20;
        @(negedge clk);
        check("repair_read_gnt", h_gnt, 1'b1);
        next();
        idle_inputs();
        next();
        @(negedge clk);
        check("repair_read_data", {h_rvalid, h_rdata}, {1'b1, 8'h7A});
        next();

        check("no_write_in_writeback_slot", 32'(collisions), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmr_scrub_ctrl.md
# tmr_scrub_ctrl

Access initiator and patrol scrubber placed in front of the triplicated TMR memory. It arbitrates a single host request port against an internal patrol engine. The patrol engine issues a background read to one memory address at a fixed interval, walking the whole address space, so the memory's scrub-on-read repairs latent upsets even in words the host never reads. It also enforces the write-free slot the memory needs to complete a scrub write-back.

## Interface
- ADDR_W, 8, memory address width; depth = 2^ADDR_W
- DATA_W, 8, data width
- SCRUB_INTERVAL, 256, cycles between patrol requests (≥2)
- MAX_DEFER, 15, cycles a pending patrol may be starved by the host before it takes priority (≥1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- scrub_en  in  1  patrol engine enable
- h_req  in  1  host access request (level, held until granted)
- h_we  in  1  host write (1) / read (0)
- h_addr  in  ADDR_W  host address
- h_wdata  in  DATA_W  host write data
- h_gnt  out  1  host request accepted this cycle
- h_rvalid  out  1  host read data valid
- h_rdata  out  DATA_W  host read data
- m_we  out  1  memory write enable
- m_re  out  1  memory read enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory voted read data (2-cycle read latency)
- patrol_addr  out  ADDR_W  next address the patrol engine will read
- sweep_done  out  1  one-cycle pulse when a patrol read of address 2^ADDR_W-1 is issued
- sweep_count  out  16  completed-sweep counter (see Configuration)

## Operation
- Patrol FSM states: CNT and PEND.
  - CNT: the interval counter loads SCRUB_INTERVAL-1 and decrements each cycle while scrub_en=1. It holds while scrub_en=0. At 0 the FSM moves to PEND.
  - PEND: the patrol read waits for a slot. On issue, the interval counter reloads and the FSM returns to CNT.
  - scrub_en=0 in PEND: return to CNT, reload the interval counter, clear the defer counter.
- guard flag: registered copy of m_re. While guard=1, m_we is forced to 0, so the memory's write-back of the previous read is never pre-empted.
- Per-cycle arbitration, applied in this order:
  1. Patrol forced: PEND and defer_cnt==MAX_DEFER → issue patrol read; h_gnt=0.
  2. Host: h_req and not (h_we and guard) → h_gnt=1; drive m_we=h_we, m_re=!h_we, m_addr=h_addr, m_wdata=h_wdata.
  3. Patrol idle slot: PEND and not (2) → issue patrol read. This includes a host write stalled by guard.
  4. Otherwise: m_we=m_re=0.
- Patrol read: m_re=1, m_addr=patrol_addr. patrol_addr increments modulo 2^ADDR_W on issue. Wrap 2^ADDR_W-1→0 pulses sweep_done.
- defer_cnt increments each cycle in PEND without issue, saturates at MAX_DEFER, and clears on issue.
- Read tag pipeline: 2-stage shift of "host read issued". h_rvalid is stage 2. h_rdata = h_rvalid ? m_rdata : 0. Patrol read returns are discarded.
- m_wdata = h_wdata whenever the host is granted, otherwise 0.

## Timing
- Reset (rst=1 at a clk edge):
  - All state is cleared: CNT, interval counter reloaded, patrol_addr=0, defer_cnt=0, guard=0, tags=0, sweep_count=0.
  - Outputs are gated to 0 during rst: h_gnt, h_rvalid, h_rdata, m_we, m_re, m_addr, m_wdata, sweep_done.
  - Reset mid-sweep restarts the walk at address 0. In-flight host reads are dropped and produce no h_rvalid.
- Host read granted in cycle T → h_rvalid=1 in cycle T+2.
- Host write granted in cycle T → m_we=1 in cycle T. No response is returned.
- Read issued at T (host or patrol) → no memory write at T+1. A host write requested at T+1 is granted at T+2 at the earliest.
- Back-to-back reads are granted every cycle.
- With scrub_en=1 and no host traffic, the first patrol read issues in cycle SCRUB_INTERVAL after reset release. It then issues every SCRUB_INTERVAL+1 cycles: SCRUB_INTERVAL cycles in CNT plus one in PEND.
- A continuously requesting host delays a patrol read by at most MAX_DEFER cycles.

## Configuration
- TMR_SCRUB_STATS_EN defined: sweep_count increments on each sweep_done and saturates at 16'hFFFF.
- TMR_SCRUB_STATS_EN undefined: the counter is not built and sweep_count is tied to 0. All other behaviour is identical.

## Test plan
- Host write addr 0x10 data 0xA5, then read 0x10 → m_we not asserted in the cycle after the read. h_rvalid 2 cycles after grant with h_rdata=0xA5.
- Read at T then host write at T+1 → h_gnt=0 at T+1, granted at T+2.
- scrub_en=1, SCRUB_INTERVAL=4, idle host → patrol reads addresses 0,1,2,… every 5 cycles. sweep_done pulses when 0xFF is issued, and sweep_count=1 with TMR_SCRUB_STATS_EN.
- Corrupt replica 1 at addr 0x20 → after the patrol read of 0x20, the memory rewrites replica 1. A host read then returns the original value, and all replicas agree.
- Continuous host reads with PEND active, MAX_DEFER=3 → patrol wins on the 4th PEND cycle and h_gnt=0 in that cycle only.
- rst asserted mid-sweep at patrol_addr=0x37 with a host read in flight → no h_rvalid follows; the next patrol read is addr 0x00.
